// File: rtl/note_peak_folder_if.sv
// Purpose: bundles the frame request and the published peak table of
//          note_peak_folder into one port.
// Signals:
//   start       frame-start request (master -> slave)
//   dft_bins    packed frame, bin i = dft_bins[i*N +: N] (master -> slave)
//   busy        engine is working on a frame (slave -> master)
//   done        one-cycle pulse, new table visible this cycle
//   overrun     sticky, start arrived while busy
//   frame_max   maximum of the last published frame
//   peak_valid  per-slot peak present
//   peak_amp    per-slot merged amplitude, slot s = peak_amp[s*N +: N]
//   peak_pos    per-slot in-octave bin index, slot s = peak_pos[s*PW +: PW]
interface note_peak_folder_if #(
  parameter int N     = 16,
  parameter int BPO   = 24,
  parameter int OCT   = 5,
  parameter int SLOTS = 12
) ();
  localparam int PW = $clog2(BPO);

  logic                  start;
  logic [N*OCT*BPO-1:0]  dft_bins;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  logic [N-1:0]          frame_max;
  logic [SLOTS-1:0]      peak_valid;
  logic [SLOTS*N-1:0]    peak_amp;
  logic [SLOTS*PW-1:0]   peak_pos;

  modport master (
    output start, dft_bins,
    input  busy, done, overrun, frame_max, peak_valid, peak_amp, peak_pos
  );

  modport slave (
    input  start, dft_bins,
    output busy, done, overrun, frame_max, peak_valid, peak_amp, peak_pos
  );
endinterface

// File: rtl/note_peak_folder.sv
// Purpose: scans one DFT frame (OCT x BPO bins) a bin per clock, finds the
//          frame maximum, detects thresholded local peaks and folds every
//          octave onto SLOTS note slots. The slot table is double-buffered:
//          scratch slots are merged during the scan and copied to the
//          published registers in a single cycle.
// Ports:
//   clk   clock
//   rst   synchronous, active-low reset
//   bus   note_peak_folder_if.slave (start/dft_bins in; busy, done,
//         overrun, frame_max, peak_valid, peak_amp, peak_pos out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; start snapshots the frame
// S_MAXSCAN | BINS cycles, running maximum, threshold registered at end
// S_FOLD    | BINS detect cycles + 1 drain cycle for the merge pipeline
// S_PUBLISH | scratch table copied to the published registers
module note_peak_folder #(
  parameter int N            = 16,
  parameter int BPO          = 24,
  parameter int OCT          = 5,
  parameter int SLOTS        = 12,
  parameter int THRESH_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  note_peak_folder_if.slave   bus
);
  localparam int PW    = $clog2(BPO);
  localparam int BINS  = OCT * BPO;
  localparam int BPS   = BPO / SLOTS;
  localparam int BW    = $clog2(BINS + 1);
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SBW   = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int DEPTH = 2 ** BW;

  localparam logic [BW-1:0]  BIN_LAST = BW'(BINS - 1);
  localparam logic [BW-1:0]  BIN_END  = BW'(BINS);
  localparam logic [PW-1:0]  POS_LAST = PW'(BPO - 1);
  localparam logic [SBW-1:0] SUB_LAST = SBW'(BPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAXSCAN, S_FOLD, S_PUBLISH} state_t;

  state_t r_state, w_next;

  logic [N*BINS-1:0]  r_snap;
  logic [BW-1:0]      r_idx;
  logic [N-1:0]       r_max;
  logic [N-1:0]       r_thr;
  logic [PW-1:0]      r_pos;
  logic [SBW-1:0]     r_sub;
  logic [SW-1:0]      r_slot;

  logic               r_c_vld;
  logic [N-1:0]       r_c_amp;
  logic [PW-1:0]      r_c_pos;
  logic [SW-1:0]      r_c_slot;

  logic [SLOTS-1:0]   r_s_vld;
  logic [N-1:0]       r_s_amp  [SLOTS];
  logic [N-1:0]       r_s_best [SLOTS];
  logic [PW-1:0]      r_s_pos  [SLOTS];

  logic               r_done;
  logic               r_overrun;
  logic [N-1:0]       r_fmax;
  logic [SLOTS-1:0]   r_pvld;
  logic [SLOTS*N-1:0] r_pamp;
  logic [SLOTS*PW-1:0] r_ppos;

  logic [N-1:0]       w_bin [DEPTH];
  logic [BW-1:0]      w_idx_l, w_idx_r;
  logic [N-1:0]       w_cur, w_left, w_right, w_scan_max;
  logic               w_fold_step, w_peak;
  logic [N:0]         w_sum;
  logic [N-1:0]       w_sat;

  // The bin view is padded with zeros up to a power of two, so idx-1 at bin 0
  // (wraps to DEPTH-1) and idx+1 at the last bin both land on a zero entry.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) w_bin[k] = '0;
    for (int k = 0; k < BINS; k++)  w_bin[k] = r_snap[k*N +: N];
  end

  assign w_idx_l     = r_idx - 1'b1;
  assign w_idx_r     = r_idx + 1'b1;
  assign w_cur       = w_bin[r_idx];
  assign w_left      = w_bin[w_idx_l];
  assign w_right     = w_bin[w_idx_r];
  assign w_scan_max  = (w_cur > r_max) ? w_cur : r_max;
  assign w_fold_step = (r_state == S_FOLD) && (r_idx != BIN_END);
  assign w_peak      = w_fold_step && (w_cur > w_left) && (w_cur > w_right)
                       && (w_cur > r_thr);

  assign w_sum = {1'b0, r_s_amp[r_c_slot]} + {1'b0, r_c_amp};
  assign w_sat = w_sum[N] ? {N{1'b1}} : w_sum[N-1:0];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)        w_next = S_MAXSCAN;
      S_MAXSCAN: if (r_idx == BIN_LAST) w_next = S_FOLD;
      S_FOLD:    if (r_idx == BIN_END)  w_next = S_PUBLISH;
      S_PUBLISH:                        w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_snap    <= '0;
      r_idx     <= '0;
      r_max     <= '0;
      r_thr     <= '0;
      r_pos     <= '0;
      r_sub     <= '0;
      r_slot    <= '0;
      r_c_vld   <= 1'b0;
      r_c_amp   <= '0;
      r_c_pos   <= '0;
      r_c_slot  <= '0;
      r_s_vld   <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_s_amp[s]  <= '0;
        r_s_best[s] <= '0;
        r_s_pos[s]  <= '0;
      end
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_fmax    <= '0;
      r_pvld    <= '0;
      r_pamp    <= '0;
      r_ppos    <= '0;
    end else begin
      // Detection registers a candidate; the merge happens one cycle later,
      // which keeps the saturating adder off the neighbour-compare path.
      r_c_vld  <= w_peak;
      r_c_amp  <= w_cur;
      r_c_pos  <= r_pos;
      r_c_slot <= r_slot;
      r_done   <= (r_state == S_PUBLISH);
      if (bus.start && (r_state != S_IDLE)) r_overrun <= 1'b1;

      if (r_c_vld) begin
        if (!r_s_vld[r_c_slot]) begin
          r_s_vld[r_c_slot]  <= 1'b1;
          r_s_amp[r_c_slot]  <= r_c_amp;
          r_s_pos[r_c_slot]  <= r_c_pos;
          r_s_best[r_c_slot] <= r_c_amp;
        end else begin
          r_s_amp[r_c_slot] <= w_sat;
          if (r_c_amp > r_s_best[r_c_slot]) begin
            r_s_pos[r_c_slot]  <= r_c_pos;
            r_s_best[r_c_slot] <= r_c_amp;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_snap  <= bus.dft_bins;
            r_idx   <= '0;
            r_max   <= '0;
            r_s_vld <= '0;
            for (int s = 0; s < SLOTS; s++) begin
              r_s_amp[s]  <= '0;
              r_s_best[s] <= '0;
              r_s_pos[s]  <= '0;
            end
          end
        end
        S_MAXSCAN: begin
          r_max <= w_scan_max;
          if (r_idx == BIN_LAST) begin
            r_idx  <= '0;
            r_thr  <= w_scan_max >> THRESH_SHIFT;
            r_pos  <= '0;
            r_sub  <= '0;
            r_slot <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FOLD: begin
          if (w_fold_step) begin
            r_idx <= r_idx + 1'b1;
            // pos = idx mod BPO and slot = pos / BPS kept as wrapping counters
            if (r_pos == POS_LAST) begin
              r_pos  <= '0;
              r_sub  <= '0;
              r_slot <= '0;
            end else begin
              r_pos <= r_pos + 1'b1;
              if (r_sub == SUB_LAST) begin
                r_sub  <= '0;
                r_slot <= r_slot + 1'b1;
              end else begin
                r_sub <= r_sub + 1'b1;
              end
            end
          end
        end
        S_PUBLISH: begin
          r_fmax <= r_max;
          r_pvld <= r_s_vld;
          for (int s = 0; s < SLOTS; s++) begin
            r_pamp[s*N +: N]   <= r_s_amp[s];
            r_ppos[s*PW +: PW] <= r_s_pos[s];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.overrun    = r_overrun;
  assign bus.frame_max  = r_fmax;
  assign bus.peak_valid = r_pvld;
  assign bus.peak_amp   = r_pamp;
  assign bus.peak_pos   = r_ppos;
endmodule
